// File: rtl/adc_current_conditioner_if.sv
// Sample/result bundle for adc_current_conditioner: ADC input side, control strobes and conditioned output.
// master = sample source / consumer, slave = the conditioner.
interface adc_current_conditioner_if #(
    parameter int WIDTH = 12
);
    logic [WIDTH-1:0] adc_code;
    logic             adc_valid;
    logic             cal_start;
    logic             fault_clr;
    logic [WIDTH:0]   i_out;
    logic             i_valid;
    logic             cal_busy;
    logic             cal_done;
    logic             oc_fault;

    modport master (
        output adc_code, adc_valid, cal_start, fault_clr,
        input  i_out, i_valid, cal_busy, cal_done, oc_fault
    );

    modport slave (
        input  adc_code, adc_valid, cal_start, fault_clr,
        output i_out, i_valid, cal_busy, cal_done, oc_fault
    );
endinterface

// File: rtl/adc_current_conditioner.sv
// Offset-binary ADC code to signed current sample, with zero-offset calibration and a latched
// overcurrent flag that is only built when ADC_COND_OVERCURRENT_EN is defined.
module adc_current_conditioner #(
    parameter int WIDTH    = 12,
    parameter int CAL_LOG2 = 6,
    parameter int OC_LIMIT = 1800
) (
    input logic                          clk,
    input logic                          rst,
    adc_current_conditioner_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, CAL, RUN} state_t;

    localparam logic [WIDTH-1:0]    MIDSCALE = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CAL_LOG2-1:0] CNT_LAST = '1;

    state_t                      state;
    logic [WIDTH-1:0]            offset;
    logic [WIDTH+CAL_LOG2-1:0]   acc;
    logic [CAL_LOG2-1:0]         cnt;
    logic [WIDTH:0]              i_out_r;
    logic                        i_valid_r;
    logic                        cal_busy_r;
    logic                        cal_done_r;
    logic                        oc_fault_r;

    logic [WIDTH-1:0]            cur_off;
    logic [WIDTH:0]              diff;
    logic [WIDTH+CAL_LOG2-1:0]   acc_next;

    always_comb begin
        cur_off  = (state == IDLE) ? MIDSCALE : offset;
        diff     = {1'b0, bus.adc_code} - {1'b0, cur_off};
        acc_next = acc + {{CAL_LOG2{1'b0}}, bus.adc_code};
    end

`ifdef ADC_COND_OVERCURRENT_EN
    localparam logic [WIDTH:0] OC_LIM = OC_LIMIT[WIDTH:0];

    logic [WIDTH:0] mag;
    logic           trip;

    // Magnitude of the largest negative result still fits, since diff never reaches -2^WIDTH.
    always_comb begin
        mag  = diff[WIDTH] ? (~diff + 1'b1) : diff;
        trip = bus.adc_valid && (state != CAL) && (mag > OC_LIM);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            offset     <= MIDSCALE;
            acc        <= '0;
            cnt        <= '0;
            i_out_r    <= '0;
            i_valid_r  <= 1'b0;
            cal_busy_r <= 1'b0;
            cal_done_r <= 1'b0;
            oc_fault_r <= 1'b0;
        end else begin
            i_valid_r  <= 1'b0;
            cal_done_r <= 1'b0;
            case (state)
                IDLE, RUN: begin
                    // A sample coinciding with cal_start still uses the offset in force now.
                    if (bus.adc_valid) begin
                        i_out_r   <= diff;
                        i_valid_r <= 1'b1;
                    end
                    if (bus.cal_start) begin
                        state      <= CAL;
                        cal_busy_r <= 1'b1;
                        acc        <= '0;
                        cnt        <= '0;
                    end
                end
                CAL: begin
                    if (bus.adc_valid) begin
                        acc <= acc_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            offset     <= acc_next[WIDTH+CAL_LOG2-1:CAL_LOG2];
                            state      <= RUN;
                            cal_busy_r <= 1'b0;
                            cal_done_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    cal_busy_r <= 1'b0;
                end
            endcase
`ifdef ADC_COND_OVERCURRENT_EN
            // A new trip outranks a simultaneous clear.
            if (trip)
                oc_fault_r <= 1'b1;
            else if (bus.fault_clr)
                oc_fault_r <= 1'b0;
`else
            oc_fault_r <= 1'b0;
`endif
        end
    end

    assign bus.i_out    = i_out_r;
    assign bus.i_valid  = i_valid_r;
    assign bus.cal_busy = cal_busy_r;
    assign bus.cal_done = cal_done_r;
    assign bus.oc_fault = oc_fault_r;
endmodule

// File: tb/tb_adc_current_conditioner.sv
// Scoreboard bench for adc_current_conditioner: expected currents are queued as samples are driven
// and popped as i_valid results appear; calibration and fault state are checked against a bench model.
module tb_adc_current_conditioner;
    localparam int W  = 12;
    localparam int CL = 6;
    localparam int OL = 1800;
`ifdef ADC_COND_OVERCURRENT_EN
    localparam logic OC_EN = 1'b1;
`else
    localparam logic OC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    adc_current_conditioner_if #(.WIDTH(W)) bus ();

    adc_current_conditioner #(
        .WIDTH    (W),
        .CAL_LOG2 (CL),
        .OC_LIMIT (OL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    logic [W:0] sb[$];
    logic [W:0] last_exp;

    int   model_off;
    logic model_cal;
    int   model_acc;
    int   model_cnt;
    logic done_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.i_valid === 1'b1) begin
            if (sb.size() == 0)
                check("spurious_i_valid", 32'd1, 32'd0);
            else
                check("i_out", 32'(bus.i_out), 32'(sb.pop_front()));
        end
    end

    // One clock with the given inputs; model updates before the edge, status checked after it.
    task automatic apply(input int code, input logic valid, input logic cal, input logic clr);
        logic       was_cal;
        logic [W:0] e;
        was_cal  = model_cal;
        done_exp = 1'b0;
        bus.adc_code  = code[W-1:0];
        bus.adc_valid = valid;
        bus.cal_start = cal;
        bus.fault_clr = clr;
        if (valid) begin
            if (!was_cal) begin
                e = 13'(code - model_off);
                sb.push_back(e);
                last_exp = e;
            end else begin
                model_acc += code;
                model_cnt++;
                if (model_cnt == (1 << CL)) begin
                    model_off = model_acc >> CL;
                    model_cal = 1'b0;
                    done_exp  = 1'b1;
                end
            end
        end
        if (cal && !was_cal) begin
            model_cal = 1'b1;
            model_acc = 0;
            model_cnt = 0;
        end
        @(posedge clk);
        #1;
        bus.adc_valid = 1'b0;
        bus.cal_start = 1'b0;
        bus.fault_clr = 1'b0;
        check("cal_busy", 32'(bus.cal_busy), 32'(model_cal));
        check("cal_done", 32'(bus.cal_done), 32'(done_exp));
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        bus.adc_valid = 1'b0;
        bus.cal_start = 1'b0;
        bus.fault_clr = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        sb.delete();
        model_off = 1 << (W - 1);
        model_cal = 1'b0;
        model_acc = 0;
        model_cnt = 0;
        last_exp  = '0;
        check("rst_i_out",    32'(bus.i_out),    32'd0);
        check("rst_i_valid",  32'(bus.i_valid),  32'd0);
        check("rst_cal_busy", 32'(bus.cal_busy), 32'd0);
        check("rst_cal_done", 32'(bus.cal_done), 32'd0);
        check("rst_oc_fault", 32'(bus.oc_fault), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.adc_code  = '0;
        bus.adc_valid = 1'b0;
        bus.cal_start = 1'b0;
        bus.fault_clr = 1'b0;
        do_reset(3);

        // Midscale code reads as zero current straight out of reset.
        apply(2048, 1'b1, 1'b0, 1'b0);
        apply(0, 1'b0, 1'b0, 1'b0);
        check("i_out_hold", 32'(bus.i_out), 32'(last_exp));

        // Calibrate on 2100, cal_done lands on the cycle after the 64th sample.
        apply(0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 64; i++) apply(2100, 1'b1, 1'b0, 1'b0);
        apply(0, 1'b0, 1'b0, 1'b0);
        apply(2200, 1'b1, 1'b0, 1'b0);
        apply(1000, 1'b1, 1'b0, 1'b0);

        // Sample arriving with cal_start uses the old offset; cal_start inside CAL is ignored.
        apply(2300, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 64; i++) apply(4095, 1'b1, (i == 10), 1'b0);
        apply(0, 1'b1, 1'b0, 1'b0);
        apply(0, 1'b0, 1'b0, 1'b0);
        check("i_out_min", 32'(bus.i_out), 32'h1001);

        // Reset part way through calibration aborts it and restores midscale.
        apply(0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) apply(2500, 1'b1, 1'b0, 1'b0);
        do_reset(1);
        repeat (3) apply(0, 1'b0, 1'b0, 1'b0);
        apply(2048, 1'b1, 1'b0, 1'b0);

        // Overcurrent latch, hold, clear, and trip-wins-over-clear.
        apply(4000, 1'b1, 1'b0, 1'b0);
        check("oc_trip", 32'(bus.oc_fault), 32'(OC_EN));
        apply(2048, 1'b1, 1'b0, 1'b0);
        check("oc_hold", 32'(bus.oc_fault), 32'(OC_EN));
        apply(0, 1'b0, 1'b0, 1'b1);
        check("oc_clear", 32'(bus.oc_fault), 32'd0);
        apply(3848, 1'b1, 1'b0, 1'b0);
        check("oc_at_limit", 32'(bus.oc_fault), 32'd0);
        apply(100, 1'b1, 1'b0, 1'b1);
        check("oc_trip_vs_clr", 32'(bus.oc_fault), 32'(OC_EN));
        apply(0, 1'b0, 1'b0, 1'b1);
        check("oc_clear2", 32'(bus.oc_fault), 32'd0);

        repeat (3) apply(0, 1'b0, 1'b0, 1'b0);
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
